// File: rtl/bin2bcd_hs.sv
// rtl/bin2bcd_hs.sv - handshaked serial binary-to-BCD converter (shift-and-add-3, one bit per cycle).
// Optional leading-zero blanking output enabled by defining BIN2BCD_LZB_EN.
module bin2bcd_hs #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5,
  parameter int SIGNED = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  neg,
  output logic                  ovf
`ifdef BIN2BCD_LZB_EN
  ,
  output logic [DIGITS-1:0]     blank
`endif
);

  localparam int                CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t               r_state;
  logic [WIDTH-1:0]     r_mag;
  logic [4*DIGITS-1:0]  r_acc;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_acc_ovf;
  logic                 r_sign;
  logic [4*DIGITS-1:0]  r_bcd;
  logic                 r_neg;
  logic                 r_ovf;

  logic                 w_neg_in;
  logic [WIDTH-1:0]     w_mag;
  logic [4*DIGITS-1:0]  w_adj;
  logic [4*DIGITS-1:0]  w_acc_next;
  logic                 w_carry;
  logic                 w_ovf_next;

  // Negation of the most negative value wraps to itself, which is the exact unsigned magnitude.
  assign w_neg_in = (SIGNED != 0) && bin[WIDTH-1];
  assign w_mag    = w_neg_in ? (~bin + WIDTH'(1)) : bin;

  always_comb begin
    w_adj = r_acc;
    for (int d = 0; d < DIGITS; d++) begin
      if (r_acc[4*d +: 4] >= 4'd5) begin
        w_adj[4*d +: 4] = r_acc[4*d +: 4] + 4'd3;
      end
    end
    w_acc_next = {w_adj[4*DIGITS-2:0], r_mag[WIDTH-1]};
    w_carry    = w_adj[4*DIGITS-1];
    w_ovf_next = r_acc_ovf | w_carry;
  end

`ifdef BIN2BCD_LZB_EN
  logic [DIGITS-1:0] r_blank;
  logic [DIGITS-1:0] w_blank;
  logic              w_zero_run;

  always_comb begin
    w_blank    = '0;
    w_zero_run = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      w_zero_run = w_zero_run & (w_acc_next[4*i +: 4] == 4'd0);
      w_blank[i] = w_zero_run;
    end
    if (w_ovf_next) begin
      w_blank = '0;
    end
  end

  assign blank = r_blank;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_mag     <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_acc_ovf <= 1'b0;
      r_sign    <= 1'b0;
      r_bcd     <= '0;
      r_neg     <= 1'b0;
      r_ovf     <= 1'b0;
`ifdef BIN2BCD_LZB_EN
      r_blank   <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_mag     <= w_mag;
            r_sign    <= w_neg_in;
            r_acc     <= '0;
            r_acc_ovf <= 1'b0;
            r_cnt     <= '0;
            r_state   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_acc     <= w_acc_next;
          r_mag     <= r_mag << 1;
          r_acc_ovf <= w_ovf_next;
          r_cnt     <= (r_cnt == LAST) ? '0 : r_cnt + CNT_W'(1);
          // Result registers only change here, so they stay frozen through DONE and beyond.
          if (r_cnt == LAST) begin
            r_state <= S_DONE;
            r_bcd   <= w_ovf_next ? {DIGITS{4'h9}} : w_acc_next;
            r_neg   <= r_sign;
            r_ovf   <= w_ovf_next;
`ifdef BIN2BCD_LZB_EN
            r_blank <= w_blank;
`endif
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign bcd       = r_bcd;
  assign neg       = r_neg;
  assign ovf       = r_ovf;

endmodule

// File: doc/bin2bcd_hs.md
BIN2BCD_HS -- requirements
Module: bin2bcd_hs

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, binary input width (>=2).
REQ-002 The block SHALL have parameter DIGITS, default 5, number of BCD output digits (>=1).
REQ-003 The block SHALL have parameter SIGNED, default 0; 1 = input is two's complement.
REQ-004 The block SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-006 The block SHALL have port in_valid  in  1  input word present.
REQ-007 The block SHALL have port in_ready  out  1  block can accept a word.
REQ-008 The block SHALL have port bin  in  WIDTH  binary input word.
REQ-009 The block SHALL have port out_valid  out  1  result present.
REQ-010 The block SHALL have port out_ready  in  1  consumer takes result.
REQ-011 The block SHALL have port bcd  out  4*DIGITS  packed BCD result, digit 0 in bits [3:0].
REQ-012 The block SHALL have port neg  out  1  result is negative (always 0 when SIGNED=0).
REQ-013 The block SHALL have port ovf  out  1  magnitude exceeded 10^DIGITS-1.

Function
REQ-014 FSM states: IDLE, SHIFT, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-015 IDLE -> SHIFT on the edge where in_valid && in_ready: latch magnitude, clear BCD accumulator, clear ovf, clear bit counter.
REQ-016 Magnitude: SIGNED=1 and bin[WIDTH-1]=1 -> neg=1 and magnitude = two's-complement negation as WIDTH-bit unsigned (most negative value is handled exactly); otherwise neg=0 and magnitude = bin.
REQ-017 SHIFT: one shift-and-add-3 step per cycle, MSB of the magnitude first; each digit >=5 gets +3 before the shift.
REQ-018 Bit counter is $clog2(WIDTH) bits wide; SHIFT -> DONE on the edge completing step WIDTH. out_valid therefore rises exactly WIDTH edges after the accept edge.
REQ-019 A 1 shifted out of digit DIGITS-1 on any step SHALL set ovf (sticky for that conversion).
REQ-020 In DONE with ovf=1, bcd SHALL read all nines (every digit 4'h9); neg is unaffected.
REQ-021 bcd, neg and ovf SHALL be held stable from the cycle out_valid rises until the handshake completes.
REQ-022 DONE -> IDLE on the edge with out_valid && out_ready. in_ready rises the following cycle; no same-edge accept.
REQ-023 in_valid, bin and out_ready are ignored outside IDLE and DONE respectively; bin changing during SHIFT has no effect.
REQ-024 Outside DONE, bcd/neg/ovf keep their last values; consumers qualify them with out_valid only.

Reset
REQ-025 rst=1 SHALL immediately force state IDLE, bcd=0, neg=0, ovf=0, out_valid=0 and the bit counter to 0, independent of clk.
REQ-026 in_ready SHALL be 1 from the first cycle after rst deasserts.
REQ-027 A reset during SHIFT or DONE aborts the conversion; no out_valid is produced for it.

Configuration
REQ-028 Macro BIN2BCD_LZB_EN defined: add output port blank  out  DIGITS. blank[i]=1 iff digit i and all higher digits are zero, with i>0. blank[0] is always 0. blank is valid with out_valid and is 0 when ovf=1.
REQ-029 Macro BIN2BCD_LZB_EN undefined: port blank and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-030 WIDTH=16, DIGITS=5: accept bin=16'hFFFF -> out_valid 16 edges later, bcd=20'h65535, neg=0, ovf=0.
REQ-031 WIDTH=16, DIGITS=4: bin=16'd10000 -> ovf=1, bcd=16'h9999.
REQ-032 SIGNED=1, WIDTH=8, DIGITS=3: bin=8'h80 -> neg=1, bcd=12'h128; then bin=8'hFF -> neg=1, bcd=12'h001.
REQ-033 Backpressure: out_ready=0 for 10 cycles in DONE -> bcd/out_valid stable and in_ready=0 throughout; out_ready=1 -> IDLE next edge, in_ready=1 the cycle after.
REQ-034 Assert rst at shift step 7 of 16 -> out_valid stays 0, in_ready=1 after release; the next word (bin=16'd42) converts to 20'h00042.
REQ-035 BIN2BCD_LZB_EN defined, DIGITS=5: bin=16'd42 -> bcd=20'h00042, blank=5'b11100; bin=0 -> blank=5'b11110.
